// File: rtl/fragment_writer_if.sv
// rtl/fragment_writer_if.sv - fragment input, burst command and write data handshakes of the fragment writer
interface fragment_writer_if #(
    parameter int PIX_W  = 16,
    parameter int ADDR_W = 32
);
    logic              frag_valid;
    logic              frag_ready;
    logic [19:0]       frag_x;
    logic [19:0]       frag_y;
    logic [PIX_W-1:0]  frag_color;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [6:0]        cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [PIX_W-1:0]  wr_data;
    logic              wr_last;
    logic              frame_done;

    modport slave (
        input  frag_valid, frag_x, frag_y, frag_color, cmd_ready, wr_ready,
        output frag_ready, cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, wr_last, frame_done
    );

    modport master (
        output frag_valid, frag_x, frag_y, frag_color, cmd_ready, wr_ready,
        input  frag_ready, cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, wr_last, frame_done
    );
endinterface

// File: rtl/fragment_writer.sv
// rtl/fragment_writer.sv - packs raster-order fragments into contiguous framebuffer write bursts
module fragment_writer #(
    parameter int                H_DISP    = 1280,
    parameter int                V_DISP    = 720,
    parameter int                PIX_W     = 16,
    parameter int                BURST_LEN = 16,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] FB_BASE   = '0
) (
    input  logic              clk,
    input  logic              rst,
    fragment_writer_if.slave  bus
);
    localparam int IDX_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {FILL, CMD, DATA} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [6:0]        count_q, count_d;
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic              eof_q, eof_d;
    logic              frame_done_q, frame_done_d;
    logic [PIX_W-1:0]  buf_q [BURST_LEN];
    logic [PIX_W-1:0]  buf_d [BURST_LEN];

    logic [ADDR_W-1:0] frag_addr;
    logic              contiguous;
    logic              is_last_pix;
    logic              break_run;
    logic              accept;
    logic              last_beat;

    assign frag_addr   = FB_BASE + ADDR_W'(bus.frag_y) * ADDR_W'(H_DISP) + ADDR_W'(bus.frag_x);
    assign contiguous  = (frag_addr == start_addr_q + ADDR_W'(count_q));
    assign is_last_pix = (bus.frag_x == 20'(H_DISP - 1)) && (bus.frag_y == 20'(V_DISP - 1));
    // A non-contiguous fragment is refused so it can open the next run after the flush.
    assign break_run   = (state_q == FILL) && (count_q != 7'd0) && bus.frag_valid && !contiguous;
    assign accept      = bus.frag_valid && bus.frag_ready;
    assign last_beat   = (7'(beat_q) == count_q - 7'd1);

    assign bus.frag_ready = (state_q == FILL) && !break_run;
    assign bus.cmd_valid  = (state_q == CMD);
    assign bus.cmd_addr   = bus.cmd_valid ? start_addr_q : '0;
    assign bus.cmd_len    = bus.cmd_valid ? count_q : 7'd0;
    assign bus.wr_valid   = (state_q == DATA);
    assign bus.wr_data    = bus.wr_valid ? buf_q[beat_q] : '0;
    assign bus.wr_last    = bus.wr_valid && last_beat;
    assign bus.frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        count_d      = count_q;
        beat_d       = beat_q;
        eof_d        = eof_q;
        frame_done_d = 1'b0;
        buf_d        = buf_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d[count_q[IDX_W-1:0]] = bus.frag_color;
                    if (count_q == 7'd0) begin
                        start_addr_d = frag_addr;
                    end
                    count_d = count_q + 7'd1;
                    eof_d   = is_last_pix;
                    if ((count_q + 7'd1 == 7'(BURST_LEN)) || is_last_pix) begin
                        state_d = CMD;
                    end
                end else if (break_run) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (bus.cmd_ready) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (bus.wr_ready) begin
                    if (last_beat) begin
                        count_d      = 7'd0;
                        eof_d        = 1'b0;
                        frame_done_d = eof_q;
                        state_d      = FILL;
                    end else begin
                        beat_d = beat_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            start_addr_q <= '0;
            count_q      <= 7'd0;
            beat_q       <= '0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            eof_q        <= eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel storage is pure datapath; it is only read under count/beat control.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_fragment_writer.sv
// tb/tb_fragment_writer.sv - self-checking bench for fragment_writer against a run/burst model
module tb_fragment_writer;
    localparam int          H  = 8;
    localparam int          V  = 2;
    localparam int          BL = 4;
    localparam logic [31:0] FB = 32'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fragment_writer_if #(.PIX_W(16), .ADDR_W(32)) bus();

    fragment_writer #(
        .H_DISP(H), .V_DISP(V), .PIX_W(16), .BURST_LEN(BL), .ADDR_W(32), .FB_BASE(FB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {int addr; int len;} burst_t;
    burst_t      obs[$];
    logic [15:0] wlog[$];
    int          fd_cnt = 0;

    int          run_addr;
    logic [15:0] run_col[$];
    int          b_addr;
    logic [15:0] b_col[$];
    bit          b_eof;
    int          stage = 0;
    int          beat = 0;
    bit          fd_exp = 0;
    bit          armed = 0;
    bit          rst_seen = 0;

    always @(negedge clk) begin : model
        int  a;
        bit  contig;
        bit  exp_ready;
        bit  eof;
        bit  fd_n;
        a = int'(FB) + int'(bus.frag_y) * H + int'(bus.frag_x);
        contig = (a == run_addr + run_col.size());
        exp_ready = (stage == 0) && !(run_col.size() > 0 && bus.frag_valid && !contig);
        if (armed) begin
            chk("frag_ready", bus.frag_ready, exp_ready);
            chk("cmd_valid", bus.cmd_valid, stage == 1);
            chk("wr_valid", bus.wr_valid, stage == 2);
            chk("frame_done", bus.frame_done, fd_exp);
            if (stage == 1) begin
                chk("cmd_addr", bus.cmd_addr, b_addr);
                chk("cmd_len", bus.cmd_len, b_col.size());
            end
            if (stage == 2) begin
                chk("wr_data", bus.wr_data, b_col[beat]);
                chk("wr_last", bus.wr_last, beat == b_col.size() - 1);
            end else begin
                chk("wr_last_idle", bus.wr_last, 0);
            end
            if (rst_seen) begin
                chk("rst_cmd_addr", bus.cmd_addr, 0);
                chk("rst_cmd_len", bus.cmd_len, 0);
                chk("rst_wr_data", bus.wr_data, 0);
            end
        end
        if (bus.cmd_valid === 1'b1 && bus.cmd_ready) obs.push_back('{int'(bus.cmd_addr), int'(bus.cmd_len)});
        if (bus.wr_valid === 1'b1 && bus.wr_ready) wlog.push_back(bus.wr_data);
        if (bus.frame_done === 1'b1) fd_cnt++;
        rst_seen = 0;
        if (rst) begin
            stage = 0; beat = 0; fd_exp = 0;
            run_col.delete(); b_col.delete();
            armed = 1; rst_seen = 1;
        end else if (armed) begin
            fd_n = 0;
            case (stage)
                0: begin
                    if (bus.frag_valid && exp_ready) begin
                        if (run_col.size() == 0) run_addr = a;
                        run_col.push_back(bus.frag_color);
                        eof = (bus.frag_x == H - 1) && (bus.frag_y == V - 1);
                        if (run_col.size() == BL || eof) begin
                            b_addr = run_addr; b_col = run_col; b_eof = eof;
                            run_col.delete(); stage = 1;
                        end
                    end else if (bus.frag_valid && run_col.size() > 0 && !contig) begin
                        b_addr = run_addr; b_col = run_col; b_eof = 0;
                        run_col.delete(); stage = 1;
                    end
                end
                1: if (bus.cmd_ready) begin stage = 2; beat = 0; end
                default: begin
                    if (bus.wr_ready) begin
                        if (beat == b_col.size() - 1) begin stage = 0; fd_n = b_eof; end
                        else beat++;
                    end
                end
            endcase
            fd_exp = fd_n;
        end
    end

    int rmode = 0;
    int stall_n = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: begin bus.cmd_ready = 1'b1; bus.wr_ready = 1'b1; end
                1: begin bus.cmd_ready = 1'($urandom_range(0, 1)); bus.wr_ready = 1'($urandom_range(0, 1)); end
                default: begin
                    if (bus.cmd_valid && stall_n < 10) begin
                        bus.cmd_ready = 1'b0;
                        stall_n++;
                    end else begin
                        bus.cmd_ready = (stall_n >= 10);
                    end
                    bus.wr_ready = ~bus.wr_ready;
                end
            endcase
        end
    end

    task automatic send(input int x, input int y, input logic [15:0] c);
        int n = 0;
        bit acc = 0;
        bus.frag_valid = 1'b1;
        bus.frag_x     = 20'(x);
        bus.frag_y     = 20'(y);
        bus.frag_color = c;
        do begin
            @(negedge clk);
            acc = bus.frag_valid && bus.frag_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: fragment (%0d,%0d) not accepted after %0d cycles, required acceptance", x, y, n);
        end
        bus.frag_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_burst(input string name, input int idx, input int addr, input int len);
        if (obs.size() > idx) begin
            chk({name, "_addr"}, obs[idx].addr, addr);
            chk({name, "_len"}, obs[idx].len, len);
        end else begin
            chk({name, "_present"}, obs.size(), idx + 1);
        end
    endtask

    logic [15:0] cols[16];
    int fd0;
    int n;
    bit wv;

    initial begin
        bus.frag_valid = 1'b0; bus.frag_x = '0; bus.frag_y = '0; bus.frag_color = '0;
        bus.cmd_ready = 1'b1; bus.wr_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_frag_ready", bus.frag_ready, 1);
        chk("reset_cmd_valid", bus.cmd_valid, 0);
        chk("reset_wr_valid", bus.wr_valid, 0);
        chk("reset_wr_last", bus.wr_last, 0);
        chk("reset_frame_done", bus.frame_done, 0);
        chk("reset_cmd_len", bus.cmd_len, 0);
        @(posedge clk); #1;

        // continuous raster
        obs.delete(); wlog.delete(); fd0 = fd_cnt;
        for (int i = 0; i < 16; i++) begin
            cols[i] = 16'($urandom);
            send(i % H, i / H, cols[i]);
        end
        settle(20);
        chk("raster_bursts", obs.size(), 4);
        for (int k = 0; k < 4; k++) chk_burst("raster", k, int'(FB) + 4 * k, 4);
        chk("raster_beats", wlog.size(), 16);
        for (int i = 0; i < 16 && i < wlog.size(); i++) chk("raster_data", wlog[i], cols[i]);
        chk("raster_frame_done", fd_cnt - fd0, 1);

        // gap flush, no timeout flush, isolated last pixel
        obs.delete(); fd0 = fd_cnt;
        send(0, 0, 16'h1111); send(1, 0, 16'h2222); send(5, 0, 16'h5555);
        settle(30);
        chk("gap_bursts", obs.size(), 1);
        chk_burst("gap", 0, int'(FB), 2);
        send(7, 1, 16'hf00f);
        settle(20);
        chk("gap_bursts_after", obs.size(), 3);
        chk_burst("gap_single", 1, int'(FB) + 5, 1);
        chk_burst("last_pixel", 2, int'(FB) + 15, 1);
        chk("last_pixel_frame_done", fd_cnt - fd0, 1);

        // stalled command then toggling write ready
        obs.delete();
        stall_n = 0; rmode = 2;
        send(2, 0, 16'ha002); send(3, 0, 16'ha003); send(4, 0, 16'ha004); send(6, 0, 16'ha006);
        settle(40);
        rmode = 0;
        send(7, 1, 16'ha00f);
        settle(20);
        chk_burst("stall", 0, int'(FB) + 2, 3);
        chk_burst("stall_next", 1, int'(FB) + 6, 1);
        chk_burst("stall_eof", 2, int'(FB) + 15, 1);

        // reset during data beat 2
        send(0, 0, 16'hb000); send(1, 0, 16'hb001); send(2, 0, 16'hb002); send(3, 0, 16'hb003);
        n = 0;
        for (int t = 0; t < 40 && n < 2; t++) begin
            @(negedge clk);
            wv = bus.wr_valid && bus.wr_ready;
            @(posedge clk); #1;
            if (wv) n++;
        end
        chk("rst_reached_beat2", n, 2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_wr_valid", bus.wr_valid, 0);
        chk("midrst_cmd_valid", bus.cmd_valid, 0);
        chk("midrst_frag_ready", bus.frag_ready, 1);
        @(posedge clk); #1;
        obs.delete();
        for (int i = 0; i < 4; i++) send(i, 0, 16'(16'hc000 + i));
        settle(20);
        chk_burst("after_rst", 0, int'(FB), 4);

        // row wrap is contiguous
        obs.delete(); wlog.delete();
        send(6, 0, 16'hd006); send(7, 0, 16'hd007); send(0, 1, 16'hd100); send(1, 1, 16'hd101);
        settle(20);
        chk("wrap_bursts", obs.size(), 1);
        chk_burst("wrap", 0, 32'h1006, 4);
        if (wlog.size() == 4) chk("wrap_data2", wlog[2], 16'hd100);
        else chk("wrap_beats", wlog.size(), 4);

        // randomized runs with random back-pressure
        rmode = 1;
        for (int r = 0; r < 60; r++) begin
            int a0;
            int len;
            a0  = $urandom_range(0, 15);
            len = $urandom_range(1, 6);
            for (int j = 0; j < len && a0 + j < 16; j++) begin
                send((a0 + j) % H, (a0 + j) / H, 16'($urandom));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        send(H - 1, V - 1, 16'($urandom));
        settle(60);
        rmode = 0;
        settle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end
endmodule
